memory_block: RTL and testbench
===============================

// Module: memory_block
// PURPOSE
// - Single-port synchronous RAM with separate write and read enables and a registered read port.
// - Every location resets to a known fill value, so reads after reset without writes return that value.
// - Sits behind the memory verification interface; drives rdata straight to the bus master.
// PARAMETERS
// - ADDR_WIDTH  2      address bits; depth = 2**ADDR_WIDTH (4 words)
// - DATA_WIDTH  8      word width in bits
// - RESET_VAL   8'hFF  fill value written to every location on reset (DATA_WIDTH wide)
// PORTS
// - clk    in   1           single clock; all logic on rising edge
// - reset  in   1           asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk)
// - addr   in   ADDR_WIDTH  word address, shared by read and write
// - wr_en  in   1           write strobe
// - rd_en  in   1           read strobe
// - wdata  in   DATA_WIDTH  write data
// - rdata  out  DATA_WIDTH  registered read data
// BEHAVIOUR
// - Reset (reset==0, async): all 2**ADDR_WIDTH words <= RESET_VAL; rdata <= '0; holds while low.
// - Write: rising clk with wr_en=1 -> mem[addr] <= wdata; visible to reads from the next edge.
// - Read: rising clk with rd_en=1 -> rdata <= mem[addr]; rdata valid one cycle after rd_en is sampled.
// - rd_en=0: rdata holds its last value (no return to 0, no X).
// - wr_en=1 and rd_en=1 same edge, same addr: read-first; rdata gets the OLD contents, and the array takes wdata.
// - wr_en=1 and rd_en=1, the same rules apply for any address; the single addr serves both.
// - Addresses wrap naturally; all addr values are in range since depth = 2**ADDR_WIDTH.
// - Reset asserted mid-write or mid-read: the operation is discarded, and the array and rdata take their reset values.
// - No X propagation: with known inputs, outputs are never X after the first reset.
// STRUCTURE
// - mem_pkg: default ADDR_WIDTH/DATA_WIDTH/RESET_VAL constants, and typedefs addr_t and data_t.
// - One sub-module, memory_block_bank: storage array with async reset fill and write port.
// - The top adds the registered read mux and holds rdata.
// TESTING
// - Default read: reset low, then release; rd_en on addr 0..3 -> rdata = 8'hFF for each, one cycle after each request.
// - Write/read: write 8'h11,8'h22,8'h33,8'h44 to addr 0..3, then read 0..3 -> 11,22,33,44 in order, 1-cycle latency.
// - Read-first: mem[2]=8'hA5, then wr_en=rd_en=1 at addr 2 with wdata=8'h5A -> rdata=A5; next read at addr 2 -> 5A.
// - Hold: read addr 1 (=8'h22), then rd_en=0 for 5 cycles while addr and wdata toggle -> rdata stays 8'h22.
// - Async reset mid-run: after writes, pull reset low between edges -> rdata=0 immediately; after release, read any addr -> 8'hFF.
// - Random: 200 cycles of random wr_en/rd_en/addr/wdata against a scoreboard model -> zero mismatches.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - default geometry, fill value and word typedefs for memory_block
package mem_pkg;
    localparam int          DEF_ADDR_WIDTH = 2;
    localparam int          DEF_DATA_WIDTH = 8;
    localparam logic [7:0]  DEF_RESET_VAL  = 8'hFF;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/memory_block_bank.sv
// rtl/memory_block_bank.sv - storage array with async reset fill, write port and combinational read word
module memory_block_bank
    import mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = DEF_RESET_VAL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rd_word
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            r_mem[addr] <= wdata;
        end
    end

    // Pre-edge contents feed the read register, which gives read-first on a same-edge write.
    assign rd_word = r_mem[addr];
endmodule

// File: rtl/memory_block.sv
// rtl/memory_block.sv - single-port RAM top: bank plus registered, holding read port
module memory_block
    import mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = DEF_RESET_VAL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] r_rdata;

    memory_block_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VAL  (RESET_VAL)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .rd_word (w_rd_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (rd_en) begin
            r_rdata <= w_rd_word;
        end
    end

    assign rdata = r_rdata;
endmodule

// File: tb/tb_memory_block.sv
// tb/tb_memory_block.sv - randomized and directed bench for memory_block against an array model
module tb_memory_block;
    import mem_pkg::*;

    logic  clk;
    logic  reset;
    addr_t addr;
    logic  wr_en;
    logic  rd_en;
    data_t wdata;
    data_t rdata;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    data_t m_mem [4];
    data_t m_rdata;

    memory_block dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .wdata (wdata),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input data_t act, input data_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a plain array; the read sees the contents before this edge's write.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) m_mem[i] = 8'hFF;
            m_rdata = 8'h00;
        end else begin
            if (rd_en) m_rdata = m_mem[addr];
            if (wr_en) m_mem[addr] = wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) chk("model", rdata, m_rdata);
    end

    task automatic cyc(input logic w, input logic r, input addr_t a, input data_t d);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string nm, input addr_t a, input data_t exp);
        cyc(1'b0, 1'b1, a, 8'h00);
        chk(nm, rdata, exp);
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 8'h00);
        reset  = 1'b1;
        chk_en = 1'b1;

        for (int a = 0; a < 4; a++) read_chk("default_read", addr_t'(a), 8'hFF);

        for (int a = 0; a < 4; a++) cyc(1'b1, 1'b0, addr_t'(a), data_t'(8'h11 * (a + 1)));
        read_chk("wr_rd_0", 2'd0, 8'h11);
        read_chk("wr_rd_1", 2'd1, 8'h22);
        read_chk("wr_rd_2", 2'd2, 8'h33);
        read_chk("wr_rd_3", 2'd3, 8'h44);

        cyc(1'b1, 1'b0, 2'd2, 8'hA5);
        cyc(1'b1, 1'b1, 2'd2, 8'h5A);
        chk("read_first_old", rdata, 8'hA5);
        read_chk("read_first_new", 2'd2, 8'h5A);

        read_chk("hold_src", 2'd1, 8'h22);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, addr_t'($urandom_range(0, 3)), data_t'($urandom));
            chk("hold", rdata, 8'h22);
        end

        cyc(1'b1, 1'b0, 2'd0, 8'h77);
        cyc(1'b1, 1'b1, 2'd3, 8'h99);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_rdata", rdata, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int a = 0; a < 4; a++) read_chk("post_reset_read", addr_t'(a), 8'hFF);

        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom), 1'($urandom), addr_t'($urandom), data_t'($urandom));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
